// File: rtl/axis_scale_clip_pkg.sv
// Shared constants and arithmetic helpers for the AXI-Stream scale/round/clip block.
// Helpers work on a 64-bit signed scratch width, so IN_W may be at most 63.
package axis_scale_clip_pkg;

   localparam int DEFAULT_SHIFT = 12;
   localparam int SAT_CNT_W     = 16;
   localparam logic [SAT_CNT_W-1:0] SAT_MAX = '1;
   localparam int WIDE_W        = 64;

   typedef logic signed [WIDE_W-1:0] wide_t;

   // Requested shifts of IN_W or more collapse to IN_W-1.
   function automatic logic [31:0] effShift(input logic [31:0] s, input int inW);
      if (s >= 32'(inW)) return 32'(inW - 1);
      return s;
   endfunction

   function automatic wide_t roundBias(input logic [31:0] shamt);
      if (shamt == 32'd0) return '0;
      return wide_t'(1) << (shamt - 32'd1);
   endfunction

   function automatic wide_t clipMax(input int outW);
      return (wide_t'(1) <<< (outW - 1)) - wide_t'(1);
   endfunction

   function automatic wide_t clipMin(input int outW);
      return -(wide_t'(1) <<< (outW - 1));
   endfunction

endpackage

// File: rtl/scale_clip_lane.sv
// One channel: round half up, arithmetic right shift, then clip to the signed output range.
// Purely combinational; o_clip flags that the result was limited.
module scale_clip_lane
   import axis_scale_clip_pkg::*;
#(
   parameter int IN_W    = 32,
   parameter int OUT_W   = 16,
   parameter int SHIFT_W = 5
) (
   input  logic [IN_W-1:0]    i_data,
   input  logic [SHIFT_W-1:0] i_shift,
   output logic [OUT_W-1:0]   o_data,
   output logic               o_clip
);

   localparam logic signed [IN_W:0] MAX_V = (IN_W+1)'(clipMax(OUT_W));
   localparam logic signed [IN_W:0] MIN_V = (IN_W+1)'(clipMin(OUT_W));

   logic [31:0]         w_shamt;
   logic signed [IN_W:0] w_ext;
   logic signed [IN_W:0] w_bias;
   logic signed [IN_W:0] w_sum;
   logic signed [IN_W:0] w_shifted;

   // One guard bit keeps the rounding add from overflowing for any input.
   always_comb begin
      w_shamt   = effShift(32'(i_shift), IN_W);
      w_ext     = {i_data[IN_W-1], i_data};
      w_bias    = (IN_W+1)'(roundBias(w_shamt));
      w_sum     = w_ext + w_bias;
      w_shifted = w_sum >>> w_shamt;
      o_clip    = 1'b0;
      o_data    = w_shifted[OUT_W-1:0];
      if (w_shifted > MAX_V) begin
         o_data = MAX_V[OUT_W-1:0];
         o_clip = 1'b1;
      end else if (w_shifted < MIN_V) begin
         o_data = MIN_V[OUT_W-1:0];
         o_clip = 1'b1;
      end
   end

endmodule

// File: rtl/axis_scale_clip.sv
// Multi-channel AXI-Stream scaler: per-packet latched shift, rounding, clipping,
// a two-entry output/skid buffer and a saturating count of clipped beats.
module axis_scale_clip #(
   parameter int NUM_CH        = 2,
   parameter int IN_W          = 32,
   parameter int OUT_W         = 16,
   parameter int SHIFT_W       = 5,
   parameter int DEFAULT_SHIFT = axis_scale_clip_pkg::DEFAULT_SHIFT
) (
   input  logic                                 s00_axis_aclk,
   input  logic                                 s00_axis_areset,
   input  logic [SHIFT_W-1:0]                   shift_cfg,
   input  logic                                 sat_clear,
   input  logic [NUM_CH*IN_W-1:0]               s00_axis_tdata,
   input  logic                                 s00_axis_tvalid,
   input  logic                                 s00_axis_tlast,
   output logic                                 s00_axis_tready,
   output logic [NUM_CH*OUT_W-1:0]              m00_axis_tdata,
   output logic                                 m00_axis_tvalid,
   output logic                                 m00_axis_tlast,
   output logic [NUM_CH*OUT_W/8-1:0]            m00_axis_tstrb,
   input  logic                                 m00_axis_tready,
   output logic [axis_scale_clip_pkg::SAT_CNT_W-1:0] sat_count
);
   import axis_scale_clip_pkg::*;

   logic [SHIFT_W-1:0]      r_shift;
   logic                    r_pktStart;
   logic                    r_ready;
   logic                    r_outValid;
   logic                    r_outLast;
   logic [NUM_CH*OUT_W-1:0] r_outData;
   logic                    r_skidValid;
   logic                    r_skidLast;
   logic [NUM_CH*OUT_W-1:0] r_skidData;
   logic [SAT_CNT_W-1:0]    r_satCount;

   logic                    w_accept;
   logic                    w_outFire;
   logic                    w_skidNext;
   logic                    w_anyClip;
   logic [SHIFT_W-1:0]      w_shift;
   logic [NUM_CH*OUT_W-1:0] w_result;
   logic [NUM_CH-1:0]       w_clip;

   assign w_accept  = s00_axis_tvalid & r_ready;
   assign w_outFire = r_outValid & m00_axis_tready;
   assign w_anyClip = |w_clip;

   // The first beat of a packet uses shift_cfg directly; that same value is latched for the rest.
   assign w_shift = r_pktStart ? shift_cfg : r_shift;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
      scale_clip_lane #(
         .IN_W   (IN_W),
         .OUT_W  (OUT_W),
         .SHIFT_W(SHIFT_W)
      ) u_lane (
         .i_data (s00_axis_tdata[g*IN_W +: IN_W]),
         .i_shift(w_shift),
         .o_data (w_result[g*OUT_W +: OUT_W]),
         .o_clip (w_clip[g])
      );
   end

   always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
      if (s00_axis_areset) begin
         r_shift    <= SHIFT_W'(DEFAULT_SHIFT);
         r_pktStart <= 1'b1;
      end else if (w_accept) begin
         if (r_pktStart) r_shift <= shift_cfg;
         r_pktStart <= s00_axis_tlast;
      end
   end

   // Accepts never coincide with a full skid, since tready is the registered inverse of it.
   always_comb begin
      w_skidNext = r_skidValid;
      if (r_skidValid && w_outFire) w_skidNext = 1'b0;
      else if (w_accept && r_outValid && !w_outFire) w_skidNext = 1'b1;
   end

   always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
      if (s00_axis_areset) begin
         r_ready     <= 1'b0;
         r_outValid  <= 1'b0;
         r_outLast   <= 1'b0;
         r_outData   <= '0;
         r_skidValid <= 1'b0;
         r_skidLast  <= 1'b0;
         r_skidData  <= '0;
      end else begin
         r_ready     <= ~w_skidNext;
         r_skidValid <= w_skidNext;
         if (w_accept && (!r_outValid || w_outFire)) begin
            r_outValid <= 1'b1;
            r_outData  <= w_result;
            r_outLast  <= s00_axis_tlast;
         end else if (w_accept) begin
            r_skidData <= w_result;
            r_skidLast <= s00_axis_tlast;
         end else if (w_outFire) begin
            if (r_skidValid) begin
               r_outData <= r_skidData;
               r_outLast <= r_skidLast;
            end else begin
               r_outValid <= 1'b0;
            end
         end
      end
   end

   // A clear that coincides with a clipping beat leaves that beat counted.
   always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
      if (s00_axis_areset) begin
         r_satCount <= '0;
      end else if (sat_clear) begin
         r_satCount <= (w_accept && w_anyClip) ? SAT_CNT_W'(1) : '0;
      end else if (w_accept && w_anyClip && (r_satCount != SAT_MAX)) begin
         r_satCount <= r_satCount + SAT_CNT_W'(1);
      end
   end

   assign s00_axis_tready = r_ready;
   assign m00_axis_tvalid = r_outValid;
   assign m00_axis_tdata  = r_outData;
   assign m00_axis_tlast  = r_outLast;
   assign m00_axis_tstrb  = '1;
   assign sat_count       = r_satCount;

endmodule

// File: tb/tb_axis_scale_clip.sv
// Self-checking bench for axis_scale_clip (2 channels, 32-bit in, 16-bit out) using a
// queue-based arithmetic reference model and randomized traffic.
module tb_axis_scale_clip;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  shift_cfg;
   logic        sat_clear;
   logic [63:0] s_tdata;
   logic        s_tvalid;
   logic        s_tlast;
   logic        s_tready;
   logic [31:0] m_tdata;
   logic        m_tvalid;
   logic        m_tlast;
   logic [3:0]  m_tstrb;
   logic        m_tready;
   logic [15:0] sat_count;

   int checks = 0;
   int errors = 0;

   logic [32:0] expQ[$];
   bit          mPktStart;
   int          mShift;
   int          mSat;

   always #5 clk = ~clk;

   axis_scale_clip #(
      .NUM_CH(2), .IN_W(32), .OUT_W(16), .SHIFT_W(5), .DEFAULT_SHIFT(12)
   ) dut (
      .s00_axis_aclk  (clk),
      .s00_axis_areset(rst),
      .shift_cfg      (shift_cfg),
      .sat_clear      (sat_clear),
      .s00_axis_tdata (s_tdata),
      .s00_axis_tvalid(s_tvalid),
      .s00_axis_tlast (s_tlast),
      .s00_axis_tready(s_tready),
      .m00_axis_tdata (m_tdata),
      .m00_axis_tvalid(m_tvalid),
      .m00_axis_tlast (m_tlast),
      .m00_axis_tstrb (m_tstrb),
      .m00_axis_tready(m_tready),
      .sat_count      (sat_count)
   );

   // Reference arithmetic: plain integer rounding, shifting and limiting per channel.
   function automatic logic [31:0] refBeat(input logic [63:0] din, input int s, output bit anyClip);
      longint v;
      int     e;
      logic [31:0] r;
      e = (s > 31) ? 31 : s;
      anyClip = 1'b0;
      r = '0;
      for (int c = 0; c < 2; c++) begin
         v = longint'($signed(din[c*32 +: 32]));
         if (e > 0) v = v + (longint'(1) << (e - 1));
         v = v >>> e;
         if (v > 32767) begin
            v = 32767;
            anyClip = 1'b1;
         end else if (v < -32768) begin
            v = -32768;
            anyClip = 1'b1;
         end
         r[c*16 +: 16] = v[15:0];
      end
      return r;
   endfunction

   // Advances one clock with the currently driven inputs, updating the model from the handshakes.
   task automatic applyStimulus(output bit acc, output bit fire, output logic [31:0] fData, output logic fLast);
      bit clip;
      logic [31:0] e;
      @(negedge clk);
      acc   = s_tvalid && s_tready;
      fire  = m_tvalid && m_tready;
      fData = m_tdata;
      fLast = m_tlast;
      clip  = 1'b0;
      if (acc) begin
         if (mPktStart) mShift = int'(shift_cfg);
         e = refBeat(s_tdata, mShift, clip);
         expQ.push_back({s_tlast, e});
         mPktStart = s_tlast;
      end
      if (sat_clear) mSat = (acc && clip) ? 1 : 0;
      else if (acc && clip && mSat != 65535) mSat++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      shift_cfg = 5'd12;
      sat_clear = 1'b0;
      s_tdata = '0;
      s_tvalid = 1'b0;
      s_tlast = 1'b0;
      m_tready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid: got %b want 0", m_tvalid); end
      checks++;
      if (m_tdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_tdata: got %h want 0", m_tdata); end
      checks++;
      if (m_tlast !== 1'b0) begin errors++; $display("[TB] FAIL reset_tlast: got %b want 0", m_tlast); end
      checks++;
      if (sat_count !== 16'h0) begin errors++; $display("[TB] FAIL reset_sat: got %h want 0", sat_count); end
      checks++;
      if (s_tready !== 1'b0) begin errors++; $display("[TB] FAIL reset_tready: got %b want 0", s_tready); end
      checks++;
      if (m_tstrb !== 4'hF) begin errors++; $display("[TB] FAIL reset_tstrb: got %h want f", m_tstrb); end
      rst = 1'b0;
      mPktStart = 1'b1;
      mShift = 12;
      mSat = 0;
      expQ.delete();
      @(posedge clk);
      #1;
      checks++;
      if (s_tready !== 1'b1) begin errors++; $display("[TB] FAIL reset_release_tready: got %b want 1", s_tready); end
   endtask

   task automatic test_rounding();
      bit acc, fire;
      logic [31:0] fd;
      logic fl;
      logic [32:0] e;
      shift_cfg = 5'd12;
      m_tready = 1'b1;
      s_tdata = {32'hFFFFE800, 32'h00001800};
      s_tlast = 1'b1;
      s_tvalid = 1'b1;
      applyStimulus(acc, fire, fd, fl);
      s_tvalid = 1'b0;
      checks++;
      if (acc !== 1'b1) begin errors++; $display("[TB] FAIL round_accept: got %b want 1", acc); end
      checks++;
      if ({m_tvalid, m_tlast, m_tdata} !== {1'b1, 1'b1, 32'hFFFF0002})
         begin errors++; $display("[TB] FAIL round_value: got v=%b l=%b d=%h want v=1 l=1 d=ffff0002", m_tvalid, m_tlast, m_tdata); end
      applyStimulus(acc, fire, fd, fl);
      checks++;
      if (!fire || expQ.size() == 0) begin errors++; $display("[TB] FAIL round_fire: got fire=%b q=%0d want fire=1", fire, expQ.size()); end
      else begin
         e = expQ.pop_front();
         if ({fl, fd} !== e) begin errors++; $display("[TB] FAIL round_model: got %h want %h", {fl, fd}, e); end
      end
   endtask

   task automatic test_saturation();
      bit acc, fire;
      logic [31:0] fd;
      logic fl;
      logic [32:0] e;
      s_tdata = {32'h80000000, 32'h7FFFFFFF};
      s_tlast = 1'b1;
      s_tvalid = 1'b1;
      applyStimulus(acc, fire, fd, fl);
      s_tvalid = 1'b0;
      checks++;
      if ({m_tvalid, m_tdata} !== {1'b1, 32'h80007FFF}) begin errors++; $display("[TB] FAIL sat_value: got v=%b d=%h want v=1 d=80007fff", m_tvalid, m_tdata); end
      checks++;
      if (sat_count !== 16'd1) begin errors++; $display("[TB] FAIL sat_count_one: got %0d want 1", sat_count); end
      sat_clear = 1'b1;
      applyStimulus(acc, fire, fd, fl);
      sat_clear = 1'b0;
      checks++;
      if (!fire || expQ.size() == 0) begin errors++; $display("[TB] FAIL sat_fire: got fire=%b want 1", fire); end
      else begin
         e = expQ.pop_front();
         if ({fl, fd} !== e) begin errors++; $display("[TB] FAIL sat_model: got %h want %h", {fl, fd}, e); end
      end
      checks++;
      if (sat_count !== 16'd0) begin errors++; $display("[TB] FAIL sat_clear: got %0d want 0", sat_count); end
   endtask

   task automatic test_backpressure();
      bit acc, fire, prevStall;
      logic [31:0] fd;
      logic fl;
      logic [32:0] e, curOut, prevOut;
      int sent, got, lowCnt, gaps;
      sent = 0; got = 0; lowCnt = 0; gaps = 0;
      prevStall = 1'b0;
      prevOut = '0;
      shift_cfg = 5'd12;
      for (int c = 0; c < 40 && got < 8; c++) begin
         m_tready = !(c == 3 || c == 4);
         s_tvalid = (sent < 8);
         s_tdata = {32'(-(sent * 8192)), 32'(sent * 4096 + 100)};
         s_tlast = (sent == 7);
         if (!s_tready) lowCnt++;
         curOut = {m_tlast, m_tdata};
         if (prevStall) begin
            checks++;
            if (curOut !== prevOut) begin errors++; $display("[TB] FAIL bp_stable: got %h want %h", curOut, prevOut); end
         end
         prevStall = m_tvalid && !m_tready;
         prevOut = curOut;
         applyStimulus(acc, fire, fd, fl);
         if (acc) sent++;
         if (fire) begin
            got++;
            checks++;
            if (expQ.size() == 0) begin errors++; $display("[TB] FAIL bp_extra: got %h want none", fd); end
            else begin
               e = expQ.pop_front();
               if ({fl, fd} !== e) begin errors++; $display("[TB] FAIL bp_order: got %h want %h", {fl, fd}, e); end
            end
         end else if (c >= 5 && got < 8) begin
            gaps++;
         end
      end
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      checks++;
      if (got != 8) begin errors++; $display("[TB] FAIL bp_count: got %0d want 8", got); end
      checks++;
      if (lowCnt != 2) begin errors++; $display("[TB] FAIL bp_tready_low: got %0d want 2", lowCnt); end
      checks++;
      if (gaps != 0) begin errors++; $display("[TB] FAIL bp_gaps: got %0d want 0", gaps); end
   endtask

   task automatic test_packet_shift();
      bit acc, fire, clip;
      logic [31:0] fd, want;
      logic fl;
      logic [32:0] e;
      logic [63:0] pkt[6];
      int sent, got, sExp;
      for (int b = 0; b < 6; b++) pkt[b] = {$urandom(), 12'h0, 20'($urandom())};
      sent = 0; got = 0;
      shift_cfg = 5'd12;
      m_tready = 1'b1;
      for (int c = 0; c < 30 && got < 6; c++) begin
         if (sent == 1) shift_cfg = 5'd8;
         s_tvalid = (sent < 6);
         s_tdata = (sent < 6) ? pkt[sent] : 64'h0;
         s_tlast = (sent == 3 || sent == 5);
         applyStimulus(acc, fire, fd, fl);
         if (acc) sent++;
         if (fire) begin
            sExp = (got < 4) ? 12 : 8;
            want = refBeat(pkt[got], sExp, clip);
            checks++;
            if ({fl, fd} !== {(got == 3 || got == 5), want})
               begin errors++; $display("[TB] FAIL pkt_beat%0d: got l=%b d=%h want l=%b d=%h", got, fl, fd, (got == 3 || got == 5), want); end
            if (expQ.size() != 0) e = expQ.pop_front();
            got++;
         end
      end
      s_tvalid = 1'b0;
      s_tlast = 1'b0;
      checks++;
      if (got != 6) begin errors++; $display("[TB] FAIL pkt_count: got %0d want 6", got); end
   endtask

   task automatic test_random();
      bit acc, fire;
      logic [31:0] fd, d0, d1;
      logic fl;
      logic [32:0] e;
      acc = 1'b0;
      s_tvalid = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (!s_tvalid || acc) begin
            s_tvalid = ($urandom_range(0, 9) < 7);
            d0 = $urandom();
            d1 = $urandom();
            if ($urandom_range(0, 1) == 1) begin
               d0 = {{12{d0[19]}}, d0[19:0]};
               d1 = {{12{d1[19]}}, d1[19:0]};
            end
            s_tdata = {d1, d0};
            s_tlast = ($urandom_range(0, 3) == 0);
         end
         shift_cfg = 5'($urandom_range(0, 31));
         sat_clear = ($urandom_range(0, 15) == 0);
         m_tready = ($urandom_range(0, 9) < 7);
         applyStimulus(acc, fire, fd, fl);
         if (fire) begin
            checks++;
            if (expQ.size() == 0) begin errors++; $display("[TB] FAIL rand_extra: got %h want none", fd); end
            else begin
               e = expQ.pop_front();
               if ({fl, fd} !== e) begin errors++; $display("[TB] FAIL rand_data: got %h want %h", {fl, fd}, e); end
            end
         end
         checks++;
         if (sat_count !== 16'(mSat)) begin errors++; $display("[TB] FAIL rand_sat: got %0d want %0d", sat_count, mSat); end
      end
      s_tvalid = 1'b0;
      sat_clear = 1'b0;
      m_tready = 1'b1;
      for (int c = 0; c < 10 && expQ.size() > 0; c++) begin
         applyStimulus(acc, fire, fd, fl);
         if (fire) begin
            checks++;
            e = expQ.pop_front();
            if ({fl, fd} !== e) begin errors++; $display("[TB] FAIL rand_drain_data: got %h want %h", {fl, fd}, e); end
         end
      end
      checks++;
      if (expQ.size() != 0 || m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL rand_drain: got q=%0d v=%b want q=0 v=0", expQ.size(), m_tvalid); end
   endtask

   task automatic test_reset_midstream();
      bit acc, fire;
      logic [31:0] fd;
      logic fl;
      logic [32:0] e;
      m_tready = 1'b0;
      shift_cfg = 5'd8;
      s_tdata = {32'h80000000, 32'h7FFFFFFF};
      s_tlast = 1'b0;
      s_tvalid = 1'b1;
      for (int c = 0; c < 6 && expQ.size() < 2; c++) applyStimulus(acc, fire, fd, fl);
      s_tvalid = 1'b0;
      shift_cfg = 5'd12;
      checks++;
      if ({m_tvalid, s_tready} !== 2'b10 || sat_count !== 16'(mSat) || mSat == 0)
         begin errors++; $display("[TB] FAIL rst_prefill: got v=%b rdy=%b sat=%0d want v=1 rdy=0 sat=%0d", m_tvalid, s_tready, sat_count, mSat); end
      #2;
      rst = 1'b1;
      #1;
      expQ.delete();
      mSat = 0;
      mPktStart = 1'b1;
      mShift = 12;
      checks++;
      if (m_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_tvalid: got %b want 0", m_tvalid); end
      checks++;
      if (sat_count !== 16'h0) begin errors++; $display("[TB] FAIL rst_sat: got %0d want 0", sat_count); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      m_tready = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(acc, fire, fd, fl);
      checks++;
      if (m_tvalid !== 1'b0 || fire) begin errors++; $display("[TB] FAIL rst_stale: got v=%b want 0", m_tvalid); end
      s_tdata = {32'h00001800, 32'h00001800};
      s_tlast = 1'b1;
      s_tvalid = 1'b1;
      applyStimulus(acc, fire, fd, fl);
      s_tvalid = 1'b0;
      checks++;
      if ({acc, m_tvalid, m_tdata} !== {1'b1, 1'b1, 32'h00020002})
         begin errors++; $display("[TB] FAIL rst_first_shift: got acc=%b v=%b d=%h want acc=1 v=1 d=00020002", acc, m_tvalid, m_tdata); end
      applyStimulus(acc, fire, fd, fl);
      if (fire && expQ.size() != 0) begin
         checks++;
         e = expQ.pop_front();
         if ({fl, fd} !== e) begin errors++; $display("[TB] FAIL rst_model: got %h want %h", {fl, fd}, e); end
      end
   endtask

   task automatic test_counter_limit();
      bit acc, fire, seenMax;
      logic [31:0] fd;
      logic fl;
      logic [32:0] e;
      int n;
      n = 0;
      seenMax = 1'b0;
      m_tready = 1'b1;
      shift_cfg = 5'd12;
      s_tdata = {32'h80000000, 32'h7FFFFFFF};
      s_tlast = 1'b1;
      s_tvalid = 1'b1;
      for (int c = 0; c < 70000 && n < 65537; c++) begin
         applyStimulus(acc, fire, fd, fl);
         if (acc) n++;
         if (fire && expQ.size() != 0) begin
            e = expQ.pop_front();
            if ({fl, fd} !== e) begin checks++; errors++; $display("[TB] FAIL lim_data: got %h want %h", {fl, fd}, e); end
         end
         if (acc && n == 65535 && !seenMax) begin
            seenMax = 1'b1;
            checks++;
            if (sat_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL lim_reach: got %h want ffff", sat_count); end
         end
      end
      s_tvalid = 1'b0;
      checks++;
      if (n != 65537) begin errors++; $display("[TB] FAIL lim_beats: got %0d want 65537", n); end
      checks++;
      if (sat_count !== 16'hFFFF) begin errors++; $display("[TB] FAIL lim_hold: got %h want ffff", sat_count); end
      for (int c = 0; c < 5 && expQ.size() > 0; c++) begin
         applyStimulus(acc, fire, fd, fl);
         if (fire) e = expQ.pop_front();
      end
   endtask

   initial begin
      test_reset();
      test_rounding();
      test_saturation();
      test_backpressure();
      test_packet_shift();
      test_random();
      test_reset_midstream();
      test_counter_limit();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #950000;
      $display("[TB] FAIL watchdog: got timeout want completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
